bumper_nav_ctrl: RTL and testbench
==================================

Name: bumper_nav_ctrl

Overview:
Autonomous bump-and-turn navigation controller for the two-wheel robot base. It debounces the active-low LeftBumper/RightBumper switches and sequences the motor driver pins (L_Ena/L_Dir/R_Ena/R_Dir) through timed forward, back-up and turn phases. Motor enables are PWM-gated for speed control. It sits between the bumper inputs and the motor driver pins at the top level.

Parameters:
DEB_CYCLES, 16, consecutive stable synchronized samples needed to change a debounced bumper level (>=2)
BACK_CYCLES, 50000, exact duration in clk_i cycles of the BACK phase (>=2)
TURN_CYCLES, 25000, exact duration in clk_i cycles of a TURN phase (>=2)
PWM_BITS, 8, width of the PWM counter and the duty input
CNT_W, 20, width of the phase timer; must hold max(BACK_CYCLES, TURN_CYCLES)

Ports:
clk_i  input  1  system clock
reset  input  1  asynchronous, active-high reset
LeftBumper  input  1  raw left bumper, active-low (0 = pressed), asynchronous
RightBumper  input  1  raw right bumper, active-low, asynchronous
run_en  input  1  1 = navigate, 0 = force IDLE
duty  input  PWM_BITS  motor PWM duty; on-time = duty / 2^PWM_BITS
L_Ena  output  1  left motor enable (PWM-gated)
L_Dir  output  1  left motor direction, 1 = forward
R_Ena  output  1  right motor enable (PWM-gated)
R_Dir  output  1  right motor direction, 1 = forward
busy  output  1  1 while in BACK, TURN_L or TURN_R
state_o  output  3  current state encoding
bump_count  output  8  saturating count of accepted bumps

Behaviour:
- Reset (asynchronous, active-high): state IDLE, all counters 0, debounced bumpers released. Outputs: L_Ena=R_Ena=0, L_Dir=R_Dir=1, busy=0, state_o=0, bump_count=0.
- Bumper path:
  - 2-FF synchronizer per bumper.
  - Debounced level changes only after DEB_CYCLES consecutive equal synchronized samples that differ from the current level.
  - A press held from the first sampling edge is seen debounced on edge 2+DEB_CYCLES. The FSM reacts on the following edge.
- States (state_o): IDLE=0, FWD=1, BACK=2, TURN_L=3, TURN_R=4; other codes are unreachable and decode to IDLE.
- Transitions:
  - IDLE -> FWD when run_en=1.
  - FWD -> BACK when either debounced bumper is pressed.
    - Latch turn_side: right (TURN_R) if left is pressed or both are pressed; left (TURN_L) if only right is pressed. Left has priority.
    - bump_count += 1, saturating at 255.
  - BACK -> latched TURN_x after exactly BACK_CYCLES cycles in BACK.
  - TURN_x -> FWD after exactly TURN_CYCLES cycles.
  - run_en=0 in any state -> IDLE on the next edge; phase timer is cleared. turn_side and bump_count are held.
- Phase timer: cleared on state entry, increments each cycle, transition when timer == N-1.
- Bumps during BACK/TURN are ignored and not counted. If a bumper is still pressed on return to FWD, FWD -> BACK occurs on the next edge (FWD lasts 1 cycle).
- Motor drive (registered; outputs reflect state one cycle after the state register):
  - IDLE: Ena=0/0, Dir=1/1.
  - FWD: L_Dir=1, R_Dir=1.
  - BACK: L_Dir=0, R_Dir=0.
  - TURN_R: L_Dir=1, R_Dir=0.
  - TURN_L: L_Dir=0, R_Dir=1.
  - In FWD, BACK and TURN_x: L_Ena = R_Ena = pwm_on.
- PWM:
  - Free-running PWM_BITS counter; wraps 2^PWM_BITS-1 -> 0.
  - pwm_on = (pwm_cnt < duty), unsigned compare. duty=0 gives always off; duty=255 gives on 255/256 cycles.
  - duty is sampled each cycle; no glitch protection is required.
- Dir changes coincide with the state change; Ena is not blanked on a direction flip.
- busy = 1 in states 2-4, registered with the drive outputs.

Decomposition:
- Shared package nav_pkg:
  - state encodings (ST_IDLE..ST_TURN_R, 3 bits)
  - DIR_FWD=1, DIR_REV=0
  - turn-side enum
- Sub-module bumper_debounce (synchronizer + DEB_CYCLES counter, parameter DEB_CYCLES, active-low raw in, active-high pressed out), instantiated twice.
- FSM, phase timer, PWM and bump counter stay in bumper_nav_ctrl.

Test Plan:
All scenarios use DEB_CYCLES=4, BACK_CYCLES=8, TURN_CYCLES=6, PWM_BITS=8.
1. Reset then run_en=1, duty=128, no bumps -> state_o=1 one edge after run_en; L_Dir=R_Dir=1; L_Ena high exactly 128 of every 256 cycles; bump_count=0.
2. In FWD, LeftBumper=0 held 3 cycles then released -> no state change; bump_count stays 0 (glitch rejected).
3. In FWD, LeftBumper=0 held -> BACK entered 7 edges after first low sample with L_Dir=R_Dir=0 for exactly 8 cycles -> TURN_R for 6 cycles (L_Dir=1, R_Dir=0) -> FWD; bump_count=1.
4. In FWD, RightBumper=0 -> BACK -> TURN_L (L_Dir=0, R_Dir=1). Both bumpers falling on the same edge -> TURN_R. Bumper held through the whole maneuver -> FWD lasts 1 cycle then BACK again; bump_count increments on each entry.
5. run_en dropped mid-BACK (cycle 4) -> IDLE next edge, L_Ena=R_Ena=0 one cycle later; run_en=1 -> FWD with a fresh timer. reset asserted mid-TURN -> immediate IDLE, bump_count=0.
6. duty=0 -> Ena never high in any state. 300 forced bumps -> bump_count saturates at 255.

Source files
------------

// File: rtl/nav_pkg.sv
// Shared definitions for the bump-and-turn navigation controller:
// state codes, motor direction levels, turn side and per-state drive.
package nav_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FWD    = 3'd1;
    localparam logic [2:0] ST_BACK   = 3'd2;
    localparam logic [2:0] ST_TURN_L = 3'd3;
    localparam logic [2:0] ST_TURN_R = 3'd4;

    localparam logic DIR_FWD = 1'b1;
    localparam logic DIR_REV = 1'b0;

    typedef enum logic {
        SIDE_L = 1'b0,
        SIDE_R = 1'b1
    } turn_side_t;

    typedef struct packed {
        logic act;
        logic l_dir;
        logic r_dir;
        logic busy;
    } drive_t;

    // Turn away from the obstacle; a left hit (alone or with right) turns right.
    function automatic turn_side_t pick_side(input logic left_hit);
        return left_hit ? SIDE_R : SIDE_L;
    endfunction

    // Motor pattern for each state; unknown codes behave as IDLE.
    function automatic drive_t drive_of(input logic [2:0] st);
        drive_t d;
        d = '{act: 1'b0, l_dir: DIR_FWD, r_dir: DIR_FWD, busy: 1'b0};
        case (st)
            ST_FWD:    d = '{act: 1'b1, l_dir: DIR_FWD, r_dir: DIR_FWD, busy: 1'b0};
            ST_BACK:   d = '{act: 1'b1, l_dir: DIR_REV, r_dir: DIR_REV, busy: 1'b1};
            ST_TURN_L: d = '{act: 1'b1, l_dir: DIR_REV, r_dir: DIR_FWD, busy: 1'b1};
            ST_TURN_R: d = '{act: 1'b1, l_dir: DIR_FWD, r_dir: DIR_REV, busy: 1'b1};
            default:   d = '{act: 1'b0, l_dir: DIR_FWD, r_dir: DIR_FWD, busy: 1'b0};
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bumper_debounce.sv
// Bumper input conditioning: 2-FF synchronizer plus a stability counter.
// Ports: clk_i, reset (async, active-high), i_raw_n (active-low switch),
//        o_pressed (debounced, active-high).
module bumper_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk_i,
    input  logic reset,
    input  logic i_raw_n,
    output logic o_pressed
);

    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], ~i_raw_n};
        end
    end

    // The level flips on the DEB_CYCLES-th consecutive differing sample;
    // any sample matching the current level restarts the run.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync[1] != r_level) begin
            if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_level <= r_sync[1];
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_pressed = r_level;

endmodule

// File: rtl/bumper_nav_ctrl.sv
// Bump-and-turn navigation: FWD until a bumper hits, then BACK and TURN.
// Ports: clk_i, reset, LeftBumper/RightBumper (active-low), run_en, duty;
//        L_Ena/L_Dir/R_Ena/R_Dir motor pins, busy, state_o, bump_count.
module bumper_nav_ctrl
    import nav_pkg::*;
#(
    parameter int DEB_CYCLES  = 16,
    parameter int BACK_CYCLES = 50000,
    parameter int TURN_CYCLES = 25000,
    parameter int PWM_BITS    = 8,
    parameter int CNT_W       = 20
) (
    input  logic                clk_i,
    input  logic                reset,
    input  logic                LeftBumper,
    input  logic                RightBumper,
    input  logic                run_en,
    input  logic [PWM_BITS-1:0] duty,
    output logic                L_Ena,
    output logic                L_Dir,
    output logic                R_Ena,
    output logic                R_Dir,
    output logic                busy,
    output logic [2:0]          state_o,
    output logic [7:0]          bump_count
);

    localparam logic [CNT_W-1:0] BACK_LAST = CNT_W'(BACK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);

    logic                w_l_hit;
    logic                w_r_hit;
    logic                w_hit;
    logic                w_pwm_on;
    logic [2:0]          w_next;
    drive_t              w_drv;

    logic [2:0]          r_state;
    turn_side_t          r_side;
    logic [CNT_W-1:0]    r_timer;
    logic [PWM_BITS-1:0] r_pwm;
    logic [7:0]          r_bumps;
    logic                r_l_ena;
    logic                r_r_ena;
    logic                r_l_dir;
    logic                r_r_dir;
    logic                r_busy;

    bumper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_l (
        .clk_i     (clk_i),
        .reset     (reset),
        .i_raw_n   (LeftBumper),
        .o_pressed (w_l_hit)
    );

    bumper_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_r (
        .clk_i     (clk_i),
        .reset     (reset),
        .i_raw_n   (RightBumper),
        .o_pressed (w_r_hit)
    );

    assign w_hit    = w_l_hit | w_r_hit;
    assign w_pwm_on = (r_pwm < duty);
    assign w_drv    = drive_of(r_state);

    always_comb begin
        w_next = ST_IDLE;
        if (run_en) begin
            case (r_state)
                ST_IDLE: w_next = ST_FWD;
                ST_FWD:  w_next = w_hit ? ST_BACK : ST_FWD;
                ST_BACK: begin
                    if (r_timer == BACK_LAST) begin
                        w_next = (r_side == SIDE_R) ? ST_TURN_R : ST_TURN_L;
                    end else begin
                        w_next = ST_BACK;
                    end
                end
                ST_TURN_L: w_next = (r_timer == TURN_LAST) ? ST_FWD : ST_TURN_L;
                ST_TURN_R: w_next = (r_timer == TURN_LAST) ? ST_FWD : ST_TURN_R;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timer only runs while staying in a timed phase; any state change
    // (including a forced drop to IDLE) restarts it from zero.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_next != r_state || !w_drv.busy) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_side  <= SIDE_L;
            r_bumps <= 8'd0;
        end else if (r_state == ST_FWD && w_next == ST_BACK) begin
            r_side <= pick_side(w_l_hit);
            if (r_bumps != 8'hFF) begin
                r_bumps <= r_bumps + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_pwm <= '0;
        end else begin
            r_pwm <= r_pwm + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            r_l_ena <= 1'b0;
            r_r_ena <= 1'b0;
            r_l_dir <= DIR_FWD;
            r_r_dir <= DIR_FWD;
            r_busy  <= 1'b0;
        end else begin
            r_l_ena <= w_drv.act & w_pwm_on;
            r_r_ena <= w_drv.act & w_pwm_on;
            r_l_dir <= w_drv.l_dir;
            r_r_dir <= w_drv.r_dir;
            r_busy  <= w_drv.busy;
        end
    end

    assign L_Ena      = r_l_ena;
    assign R_Ena      = r_r_ena;
    assign L_Dir      = r_l_dir;
    assign R_Dir      = r_r_dir;
    assign busy       = r_busy;
    assign state_o    = r_state;
    assign bump_count = r_bumps;

endmodule

// File: tb/tb_bumper_nav_ctrl.sv
// Scenario bench for bumper_nav_ctrl: expected per-cycle states are queued
// by each scenario and drained by a monitor one clock at a time.
module tb_bumper_nav_ctrl;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FWD    = 3'd1;
    localparam logic [2:0] S_BACK   = 3'd2;
    localparam logic [2:0] S_TURN_L = 3'd3;
    localparam logic [2:0] S_TURN_R = 3'd4;

    logic       clk_i = 1'b0;
    logic       reset = 1'b1;
    logic       LeftBumper = 1'b1;
    logic       RightBumper = 1'b1;
    logic       run_en = 1'b0;
    logic [7:0] duty = 8'd0;
    logic       L_Ena;
    logic       L_Dir;
    logic       R_Ena;
    logic       R_Dir;
    logic       busy;
    logic [2:0] state_o;
    logic [7:0] bump_count;

    int         n_chk = 0;
    int         n_fail = 0;
    logic [2:0] exp_q[$];
    logic [2:0] last_st = S_IDLE;
    logic [2:0] e;
    logic [2:0] dexp;
    logic       ena_forbid = 1'b0;
    int         exp_bumps = 0;

    bumper_nav_ctrl #(
        .DEB_CYCLES  (4),
        .BACK_CYCLES (8),
        .TURN_CYCLES (6),
        .PWM_BITS    (8),
        .CNT_W       (20)
    ) dut (
        .clk_i       (clk_i),
        .reset       (reset),
        .LeftBumper  (LeftBumper),
        .RightBumper (RightBumper),
        .run_en      (run_en),
        .duty        (duty),
        .L_Ena       (L_Ena),
        .L_Dir       (L_Dir),
        .R_Ena       (R_Ena),
        .R_Dir       (R_Dir),
        .busy        (busy),
        .state_o     (state_o),
        .bump_count  (bump_count)
    );

    always #5 clk_i = ~clk_i;

    // Expected {L_Dir, R_Dir, busy} for a given state.
    function automatic logic [2:0] drv_exp(input logic [2:0] st);
        case (st)
            S_FWD:    return 3'b110;
            S_BACK:   return 3'b001;
            S_TURN_L: return 3'b011;
            S_TURN_R: return 3'b101;
            default:  return 3'b110;
        endcase
    endfunction

    // Scoreboard consumer: state_o matches this cycle's expectation, the
    // drive pins match the previous cycle's state.
    always @(posedge clk_i) begin
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            dexp = drv_exp(last_st);
            n_chk++;
            if (state_o !== e) begin
                n_fail++;
                $display("FAIL state_o: got %0d expected %0d at %0t", state_o, e, $time);
            end
            n_chk++;
            if ({L_Dir, R_Dir, busy} !== dexp) begin
                n_fail++;
                $display("FAIL drive {L_Dir,R_Dir,busy}: got %b expected %b at %0t",
                         {L_Dir, R_Dir, busy}, dexp, $time);
            end
            if (ena_forbid) begin
                n_chk++;
                if ({L_Ena, R_Ena} !== 2'b00) begin
                    n_fail++;
                    $display("FAIL ena_duty0: got %b expected 00 at %0t", {L_Ena, R_Ena}, $time);
                end
            end
            last_st = e;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #3;
        end
    endtask

    task automatic push(input logic [2:0] st, input int n);
        repeat (n) exp_q.push_back(st);
    endtask

    task automatic test_reset();
        step(2);
        n_chk++;
        if ({state_o, L_Ena, R_Ena, L_Dir, R_Dir, busy} !== {3'd0, 5'b00110}) begin
            n_fail++;
            $display("FAIL reset_outputs: got st=%0d %b expected st=0 00110", state_o,
                     {L_Ena, R_Ena, L_Dir, R_Dir, busy});
        end
        n_chk++;
        if (bump_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_bumps: got %0d expected 0", bump_count);
        end
        reset = 1'b0;
        push(S_IDLE, 3);
        step(3);
    endtask

    task automatic test_fwd_pwm();
        int cl;
        int cr;
        duty = 8'd128;
        run_en = 1'b1;
        push(S_FWD, 3);
        step(3);
        cl = 0;
        cr = 0;
        repeat (256) begin
            step(1);
            cl += int'(L_Ena);
            cr += int'(R_Ena);
        end
        n_chk++;
        if (cl != 128 || cr != 128) begin
            n_fail++;
            $display("FAIL pwm_128: got L=%0d R=%0d expected 128", cl, cr);
        end
        duty = 8'd255;
        step(2);
        cl = 0;
        repeat (256) begin
            step(1);
            cl += int'(L_Ena);
        end
        n_chk++;
        if (cl != 255) begin
            n_fail++;
            $display("FAIL pwm_255: got %0d expected 255", cl);
        end
        duty = 8'd128;
        n_chk++;
        if (bump_count !== 8'd0 || L_Dir !== 1'b1 || R_Dir !== 1'b1) begin
            n_fail++;
            $display("FAIL fwd_idle_bumps: got cnt=%0d dirs=%b%b expected 0 11",
                     bump_count, L_Dir, R_Dir);
        end
    endtask

    task automatic test_glitch();
        LeftBumper = 1'b0;
        push(S_FWD, 13);
        step(3);
        LeftBumper = 1'b1;
        step(10);
        n_chk++;
        if (bump_count !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_bumps: got %0d expected 0", bump_count);
        end
    endtask

    task automatic test_bump(input logic l, input logic r, input logic [2:0] turn, input string nm);
        LeftBumper = ~l;
        RightBumper = ~r;
        push(S_FWD, 6);
        push(S_BACK, 8);
        push(turn, 6);
        push(S_FWD, 4);
        exp_bumps++;
        step(7);
        LeftBumper = 1'b1;
        RightBumper = 1'b1;
        step(17);
        n_chk++;
        if (exp_q.size() != 0 || bump_count !== 8'(exp_bumps)) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d left=%0d expected cnt=%0d left=0",
                     nm, bump_count, exp_q.size(), exp_bumps);
        end
    endtask

    task automatic test_back_to_back();
        LeftBumper = 1'b0;
        push(S_FWD, 6);
        push(S_BACK, 8);
        push(S_TURN_R, 6);
        push(S_FWD, 1);
        push(S_BACK, 8);
        push(S_TURN_R, 6);
        push(S_FWD, 4);
        exp_bumps += 2;
        step(22);
        LeftBumper = 1'b1;
        step(17);
        n_chk++;
        if (exp_q.size() != 0 || bump_count !== 8'(exp_bumps)) begin
            n_fail++;
            $display("FAIL held_bumper: got cnt=%0d expected %0d", bump_count, exp_bumps);
        end
    endtask

    task automatic test_run_en_and_reset();
        duty = 8'd255;
        LeftBumper = 1'b0;
        push(S_FWD, 6);
        push(S_BACK, 4);
        push(S_IDLE, 10);
        exp_bumps++;
        step(10);
        run_en = 1'b0;
        LeftBumper = 1'b1;
        step(2);
        n_chk++;
        if ({L_Ena, R_Ena} !== 2'b00) begin
            n_fail++;
            $display("FAIL drop_ena: got %b expected 00", {L_Ena, R_Ena});
        end
        n_chk++;
        if (bump_count !== 8'(exp_bumps)) begin
            n_fail++;
            $display("FAIL drop_bumps: got %0d expected %0d", bump_count, exp_bumps);
        end
        step(8);
        run_en = 1'b1;
        LeftBumper = 1'b0;
        push(S_FWD, 6);
        push(S_BACK, 8);
        push(S_TURN_R, 3);
        step(7);
        LeftBumper = 1'b1;
        step(10);
        reset = 1'b1;
        #1;
        n_chk++;
        if (state_o !== S_IDLE || bump_count !== 8'd0 || busy !== 1'b0 || L_Ena !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got st=%0d cnt=%0d busy=%b ena=%b expected 0 0 0 0",
                     state_o, bump_count, busy, L_Ena);
        end
        exp_bumps = 0;
        last_st = S_IDLE;
        step(1);
        reset = 1'b0;
        push(S_FWD, 3);
        step(3);
    endtask

    task automatic test_duty0_saturate();
        duty = 8'd0;
        ena_forbid = 1'b1;
        LeftBumper = 1'b0;
        push(S_FWD, 6);
        repeat (300) begin
            push(S_BACK, 8);
            push(S_TURN_R, 6);
            push(S_FWD, 1);
        end
        push(S_BACK, 8);
        push(S_TURN_R, 6);
        push(S_FWD, 3);
        step(6 + 300 * 15);
        LeftBumper = 1'b1;
        step(17);
        n_chk++;
        if (bump_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturate: got %0d expected 255", bump_count);
        end
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sat_drain: got %0d pending expected 0", exp_q.size());
        end
        ena_forbid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_pwm();
        test_glitch();
        test_bump(1'b1, 1'b0, S_TURN_R, "bump_left");
        test_bump(1'b0, 1'b1, S_TURN_L, "bump_right");
        test_bump(1'b1, 1'b1, S_TURN_R, "bump_both");
        test_back_to_back();
        test_run_en_and_reset();
        test_duty0_saturate();
        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
